soft_tbm_event_decoder: RTL

- Receive end of the soft TBM DAQ stream. Parses the 16-bit words (header A/8, ROC data, trailer E/C) into per-event records.
- Checks framing, reserved bits, token/ROC-data consistency and event-number continuity.
- Sits after the DAQ FIFO writer in DTB test/readout paths. Used as a monitor in test benches and as an on-chip event checker.

---
 rtl/soft_tbm_pkg.sv | 52 +++++
 rtl/soft_tbm_evnum_check.sv | 43 ++++
 rtl/soft_tbm_event_decoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/soft_tbm_pkg.sv
// ============================================================================
// soft_tbm_pkg : shared constants, state encoding and word-format helper
//                for the soft TBM event decoder.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package soft_tbm_pkg;

  localparam logic [3:0] TAG_HDR1 = 4'hA;
  localparam logic [3:0] TAG_HDR2 = 4'h8;
  localparam logic [3:0] TAG_TRL1 = 4'hE;
  localparam logic [3:0] TAG_TRL2 = 4'hC;

  localparam int FLG_NTOK = 7;
  localparam int FLG_REST = 6;
  localparam int FLG_RESR = 5;
  localparam int FLG_SYNC = 3;
  localparam int FLG_CLT  = 2;
  localparam int FLG_CAL  = 1;
  localparam int FLG_STKF = 0;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_SEQ   = 3'd1;
  localparam logic [2:0] ERR_FMT   = 3'd2;
  localparam logic [2:0] ERR_EVNUM = 3'd3;
  localparam logic [2:0] ERR_NTOK  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR2 = 2'd1,
    ST_DATA = 2'd2,
    ST_TRL2 = 2'd3
  } state_e;

  // Reserved-bit violation for framing words; ROC data has no reserved bits.
  function automatic logic fmt_error(input logic [15:0] word);
    logic bad;
    bad = 1'b0;
    case (word[15:12])
      TAG_HDR1: bad = |word[11:8];
      TAG_HDR2: bad = |word[11:4];
      TAG_TRL1: bad = (|word[11:8]) | word[4];
      TAG_TRL2: bad = (|word[11:8]) | (|word[5:4]);
      default:  bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/soft_tbm_evnum_check.sv
// ============================================================================
// soft_tbm_evnum_check : event-number continuity tracker (last good number
//                        and first-event marker), flags EVNUM violations.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module soft_tbm_evnum_check (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       check_i,
  input  logic [7:0] number_i,
  input  logic       sync_i,
  output logic       err_o
);

  logic [7:0] last_good_q;
  logic       first_q;

  // A sync event must restart at 0; otherwise numbers step by one mod 256.
  always_comb begin
    err_o = 1'b0;
    if (check_i) begin
      if (sync_i)
        err_o = (number_i != 8'd0);
      else if (!first_q)
        err_o = (number_i != (last_good_q + 8'd1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_good_q <= 8'd0;
      first_q     <= 1'b1;
    end else if (check_i) begin
      last_good_q <= number_i;
      first_q     <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/soft_tbm_event_decoder.sv
// ============================================================================
// soft_tbm_event_decoder : parses the soft TBM DAQ word stream into event
//                          records and reports framing/format/content errors.
//                          Optional statistics: SOFT_TBM_EVENT_DECODER_STATS_EN
// Revision               : 1.0
// ============================================================================
`default_nettype none

module soft_tbm_event_decoder
  import soft_tbm_pkg::*;
#(
  parameter int WCNT_W      = 12,
  parameter bit CHECK_EVNUM = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              din_write,
  input  logic [15:0]       din,
  output logic              evt_valid,
  output logic [7:0]        evt_number,
  output logic [3:0]        evt_trg_pos,
  output logic [7:0]        evt_flags,
  output logic [3:0]        evt_stack,
  output logic              evt_ares,
  output logic              evt_pkam,
  output logic [WCNT_W-1:0] evt_roc_words,
  output logic              err_valid,
  output logic [2:0]        err_code
`ifdef SOFT_TBM_EVENT_DECODER_STATS_EN
  ,
  output logic [15:0]       stat_events,
  output logic [15:0]       stat_errors,
  output logic [15:0]       stat_pkam
`endif
);

  localparam logic [WCNT_W-1:0] CNT_MAX = {WCNT_W{1'b1}};
  localparam logic [WCNT_W-1:0] CNT_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [7:0]        num_q, num_d;
  logic [3:0]        trg_q, trg_d;
  logic [7:0]        flags_q, flags_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] w_tag;
  logic       w_seq_err, w_fmt_err, w_evnum_raw, w_ntok_err, w_complete;
  logic [2:0] err_code_d;

  assign w_tag = din[15:12];

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    trg_d      = trg_q;
    flags_d    = flags_q;
    cnt_d      = cnt_q;
    w_seq_err  = 1'b0;
    w_complete = 1'b0;
    if (din_write) begin
      // A header always starts a new event; any partial one is abandoned.
      if (w_tag == TAG_HDR1) begin
        num_d     = din[7:0];
        state_d   = ST_HDR2;
        w_seq_err = (state_q != ST_IDLE);
      end else begin
        case (state_q)
          ST_HDR2: begin
            if (w_tag == TAG_HDR2) begin
              trg_d   = din[3:0];
              cnt_d   = '0;
              state_d = ST_DATA;
            end else begin
              w_seq_err = 1'b1;
              state_d   = ST_IDLE;
            end
          end
          ST_DATA: begin
            if (w_tag == TAG_TRL1) begin
              flags_d = din[7:0];
              state_d = ST_TRL2;
            end else if (w_tag == TAG_HDR2 || w_tag == TAG_TRL2) begin
              w_seq_err = 1'b1;
              state_d   = ST_IDLE;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          ST_TRL2: begin
            w_complete = (w_tag == TAG_TRL2);
            w_seq_err  = (w_tag != TAG_TRL2);
            state_d    = ST_IDLE;
          end
          default: begin
            w_seq_err = 1'b1;
            state_d   = ST_IDLE;
          end
        endcase
      end
    end
  end

  soft_tbm_evnum_check u_evnum_check (
    .clk      (clk),
    .rst_n    (reset_n),
    .check_i  (w_complete),
    .number_i (num_q),
    .sync_i   (flags_q[FLG_SYNC]),
    .err_o    (w_evnum_raw)
  );

  assign w_fmt_err  = din_write & fmt_error(din);
  assign w_ntok_err = w_complete & flags_q[FLG_NTOK] & (cnt_q != '0);

  always_comb begin
    err_code_d = ERR_NONE;
    if (w_seq_err)                        err_code_d = ERR_SEQ;
    else if (w_fmt_err)                   err_code_d = ERR_FMT;
    else if (CHECK_EVNUM && w_evnum_raw)  err_code_d = ERR_EVNUM;
    else if (w_ntok_err)                  err_code_d = ERR_NTOK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      num_q         <= 8'd0;
      trg_q         <= 4'd0;
      flags_q       <= 8'd0;
      cnt_q         <= '0;
      evt_valid     <= 1'b0;
      evt_number    <= 8'd0;
      evt_trg_pos   <= 4'd0;
      evt_flags     <= 8'd0;
      evt_stack     <= 4'd0;
      evt_ares      <= 1'b0;
      evt_pkam      <= 1'b0;
      evt_roc_words <= '0;
      err_valid     <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      trg_q     <= trg_d;
      flags_q   <= flags_d;
      cnt_q     <= cnt_d;
      evt_valid <= w_complete;
      err_valid <= (err_code_d != ERR_NONE);
      err_code  <= err_code_d;
      // Record fields only move on completion so they hold between pulses.
      if (w_complete) begin
        evt_number    <= num_q;
        evt_trg_pos   <= trg_q;
        evt_flags     <= flags_q;
        evt_stack     <= din[3:0];
        evt_ares      <= din[7];
        evt_pkam      <= din[6];
        evt_roc_words <= cnt_q;
      end
    end
  end

`ifdef SOFT_TBM_EVENT_DECODER_STATS_EN
  logic [15:0] stat_events_q, stat_errors_q, stat_pkam_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_events_q <= 16'd0;
      stat_errors_q <= 16'd0;
      stat_pkam_q   <= 16'd0;
    end else begin
      if (w_complete && stat_events_q != 16'hFFFF)
        stat_events_q <= stat_events_q + 16'd1;
      if (err_code_d != ERR_NONE && stat_errors_q != 16'hFFFF)
        stat_errors_q <= stat_errors_q + 16'd1;
      if (w_complete && din[6] && stat_pkam_q != 16'hFFFF)
        stat_pkam_q <= stat_pkam_q + 16'd1;
    end
  end

  assign stat_events = stat_events_q;
  assign stat_errors = stat_errors_q;
  assign stat_pkam   = stat_pkam_q;
`endif

endmodule

`default_nettype wire
